regfile_wb_arbiter: RTL and testbench

- Write-back arbiter that sits directly upstream of the three-ported register file and drives its single write port (we3/wa3/wd3).
- Merges two result sources onto that port:
  - the in-order pipeline write-back, which is never delayed;
  - results from a long-latency unit (mul/div/load-miss), taken over a valid/ready handshake and buffered in a small FIFO.
- Keeps a per-register busy scoreboard and raises stall_req so buffered results cannot be starved.

---
 rtl/regfile_pkg.sv | 11 +
 rtl/wb_fifo.sv | 58 +++++
 rtl/regfile_wb_arbiter.sv | 110 +++++++++++
 tb/tb_regfile_wb_arbiter.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared register-file widths and write-back request type
package regfile_pkg;
    localparam int NREG = 32;
    localparam int RA_W = 5;
    localparam int XLEN = 32;

    typedef struct packed {
        logic [RA_W-1:0] wa;
        logic [XLEN-1:0] wd;
    } wb_req_t;
endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - synchronous FIFO of buffered long-latency write-back results
module wb_fifo
    import regfile_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic    clk,
    input  logic    reset_n,
    input  logic    push,
    input  wb_req_t din,
    input  logic    pop,
    output logic    full,
    output logic    empty,
    output wb_req_t head
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    wb_req_t         mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic            do_push;
    logic            do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Storage carries no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - merges pipeline and long-latency results onto the register-file write port
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            p_we,
    input  logic [RA_W-1:0] p_wa,
    input  logic [XLEN-1:0] p_wd,
    input  logic            s_valid,
    input  logic [RA_W-1:0] s_wa,
    input  logic [XLEN-1:0] s_wd,
    output logic            s_ready,
    input  logic            iss_valid,
    input  logic [RA_W-1:0] iss_wa,
    output logic            we3,
    output logic [RA_W-1:0] wa3,
    output logic [XLEN-1:0] wd3,
    output logic [NREG-1:0] busy,
    output logic            stall_req,
    output logic            waw_err
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] SLIM = SW'(STARVE_LIMIT);

    wb_req_t         head;
    wb_req_t         din;
    logic            full;
    logic            empty;
    logic            p_live;
    logic            pop;
    logic            push;
    logic            waw_hit;
    logic [NREG-1:0] busy_next;
    logic [SW-1:0]   starve_cnt;
    logic [SW-1:0]   starve_next;

    assign s_ready = !full;
    // Entries aimed at r0 are accepted but never stored.
    assign push    = s_valid && s_ready && (s_wa != '0);
    assign din     = '{wa: s_wa, wd: s_wd};
    assign p_live  = p_we && (p_wa != '0);
    assign pop     = !p_live && !empty;

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .din     (din),
        .pop     (pop),
        .full    (full),
        .empty   (empty),
        .head    (head)
    );

    always_comb begin
        we3 = 1'b0;
        wa3 = '0;
        wd3 = '0;
        if (p_live) begin
            we3 = 1'b1;
            wa3 = p_wa;
            wd3 = p_wd;
        end else if (!empty) begin
            we3 = 1'b1;
            wa3 = head.wa;
            wd3 = head.wd;
        end
    end

    // Set is applied after clear so a same-cycle reissue keeps the register busy.
    always_comb begin
        busy_next = busy;
        if (pop) begin
            busy_next[head.wa] = 1'b0;
        end
        if (iss_valid && (iss_wa != '0)) begin
            busy_next[iss_wa] = 1'b1;
        end
    end

    assign waw_hit = (p_live && busy[p_wa]) ||
                     (iss_valid && (iss_wa != '0) && busy[iss_wa]);

    always_comb begin
        starve_next = starve_cnt;
        if (empty || pop) begin
            starve_next = '0;
        end else if (starve_cnt != SLIM) begin
            starve_next = starve_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            busy       <= '0;
            waw_err    <= 1'b0;
            starve_cnt <= '0;
            stall_req  <= 1'b0;
        end else begin
            busy       <= busy_next;
            waw_err    <= waw_err || waw_hit;
            starve_cnt <= starve_next;
            stall_req  <= (starve_next == SLIM);
        end
    end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - directed vector bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;
    logic        clk;
    logic        reset_n;
    logic        p_we;
    logic [4:0]  p_wa;
    logic [31:0] p_wd;
    logic        s_valid;
    logic [4:0]  s_wa;
    logic [31:0] s_wd;
    logic        s_ready;
    logic        iss_valid;
    logic [4:0]  iss_wa;
    logic        we3;
    logic [4:0]  wa3;
    logic [31:0] wd3;
    logic [31:0] busy;
    logic        stall_req;
    logic        waw_err;

    int n_vec = 0;
    int n_bad = 0;

    regfile_wb_arbiter #(.DEPTH(4), .STARVE_LIMIT(8)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .p_we      (p_we),
        .p_wa      (p_wa),
        .p_wd      (p_wd),
        .s_valid   (s_valid),
        .s_wa      (s_wa),
        .s_wd      (s_wd),
        .s_ready   (s_ready),
        .iss_valid (iss_valid),
        .iss_wa    (iss_wa),
        .we3       (we3),
        .wa3       (wa3),
        .wd3       (wd3),
        .busy      (busy),
        .stall_req (stall_req),
        .waw_err   (waw_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        rst_n;
        logic        p_we;
        logic [4:0]  p_wa;
        logic [31:0] p_wd;
        logic        s_valid;
        logic [4:0]  s_wa;
        logic [31:0] s_wd;
        logic        iss_valid;
        logic [4:0]  iss_wa;
        logic        e_we;
        logic [4:0]  e_wa;
        logic [31:0] e_wd;
        logic        e_rdy;
        logic [31:0] e_busy;
        logic        e_stall;
        logic        e_waw;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        input logic rst_n, input logic pwe, input logic [4:0] pwa, input logic [31:0] pwd,
        input logic sv, input logic [4:0] swa, input logic [31:0] swd,
        input logic iv, input logic [4:0] iwa,
        input logic ewe, input logic [4:0] ewa, input logic [31:0] ewd,
        input logic erdy, input logic [31:0] ebusy, input logic estall, input logic ewaw);
        vec_t v;
        v.rst_n = rst_n; v.p_we = pwe; v.p_wa = pwa; v.p_wd = pwd;
        v.s_valid = sv; v.s_wa = swa; v.s_wd = swd;
        v.iss_valid = iv; v.iss_wa = iwa;
        v.e_we = ewe; v.e_wa = ewa; v.e_wd = ewd; v.e_rdy = erdy;
        v.e_busy = ebusy; v.e_stall = estall; v.e_waw = ewaw;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // Drive inputs just after the falling edge and let them settle before checking.
    task automatic drive(input logic rn, input logic pwe, input logic [4:0] pwa, input logic [31:0] pwd,
                         input logic sv, input logic [4:0] swa, input logic [31:0] swd,
                         input logic iv, input logic [4:0] iwa);
        @(negedge clk);
        reset_n = rn; p_we = pwe; p_wa = pwa; p_wd = pwd;
        s_valid = sv; s_wa = swa; s_wd = swd;
        iss_valid = iv; iss_wa = iwa;
        #2;
    endtask

    task automatic idle();
        drive(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    endtask

    initial begin
        int n;
        vec_t v;

        // rst pwe pwa pwd         sv swa swd            iv iwa | we wa wd           rdy busy          stl waw
        tbl.push_back(mk(0, 0, 0, 0,           1, 4, 32'h1,        0, 0,  0, 0, 0,            1, 32'h0,     0, 0));
        tbl.push_back(mk(1, 0, 0, 0,           0, 0, 0,            0, 0,  0, 0, 0,            1, 32'h0,     0, 0));
        tbl.push_back(mk(1, 0, 0, 0,           0, 0, 0,            1, 5,  0, 0, 0,            1, 32'h0,     0, 0));
        tbl.push_back(mk(1, 0, 0, 0,           1, 5, 32'hDEADBEEF, 0, 0,  0, 0, 0,            1, 32'h20,    0, 0));
        tbl.push_back(mk(1, 0, 0, 0,           0, 0, 0,            0, 0,  1, 5, 32'hDEADBEEF, 1, 32'h20,    0, 0));
        tbl.push_back(mk(1, 0, 0, 0,           0, 0, 0,            0, 0,  0, 0, 0,            1, 32'h0,     0, 0));
        tbl.push_back(mk(1, 0, 0, 0,           1, 7, 32'h11,       1, 7,  0, 0, 0,            1, 32'h0,     0, 0));
        tbl.push_back(mk(1, 1, 3, 32'h22,      0, 0, 0,            0, 0,  1, 3, 32'h22,       1, 32'h80,    0, 0));
        tbl.push_back(mk(1, 1, 3, 32'h22,      0, 0, 0,            0, 0,  1, 3, 32'h22,       1, 32'h80,    0, 0));
        tbl.push_back(mk(1, 1, 3, 32'h22,      0, 0, 0,            0, 0,  1, 3, 32'h22,       1, 32'h80,    0, 0));
        tbl.push_back(mk(1, 0, 0, 0,           0, 0, 0,            0, 0,  1, 7, 32'h11,       1, 32'h80,    0, 0));
        tbl.push_back(mk(1, 0, 0, 0,           0, 0, 0,            1, 0,  0, 0, 0,            1, 32'h0,     0, 0));
        tbl.push_back(mk(1, 0, 0, 0,           1, 0, 32'hBAD,      0, 0,  0, 0, 0,            1, 32'h0,     0, 0));
        tbl.push_back(mk(1, 0, 0, 0,           0, 0, 0,            0, 0,  0, 0, 0,            1, 32'h0,     0, 0));
        tbl.push_back(mk(1, 1, 0, 32'h55,      0, 0, 0,            0, 0,  0, 0, 0,            1, 32'h0,     0, 0));
        tbl.push_back(mk(1, 0, 0, 0,           1, 2, 32'h33,       0, 0,  0, 0, 0,            1, 32'h0,     0, 0));
        tbl.push_back(mk(1, 1, 0, 32'h55,      0, 0, 0,            0, 0,  1, 2, 32'h33,       1, 32'h0,     0, 0));
        tbl.push_back(mk(1, 0, 0, 0,           0, 0, 0,            1, 9,  0, 0, 0,            1, 32'h0,     0, 0));
        tbl.push_back(mk(1, 1, 9, 32'h99,      0, 0, 0,            0, 0,  1, 9, 32'h99,       1, 32'h200,   0, 0));
        tbl.push_back(mk(1, 0, 0, 0,           0, 0, 0,            0, 0,  0, 0, 0,            1, 32'h200,   0, 1));
        tbl.push_back(mk(1, 0, 0, 0,           0, 0, 0,            0, 0,  0, 0, 0,            1, 32'h200,   0, 1));
        tbl.push_back(mk(0, 0, 0, 0,           0, 0, 0,            0, 0,  0, 0, 0,            1, 32'h200,   0, 1));
        tbl.push_back(mk(1, 0, 0, 0,           0, 0, 0,            1, 4,  0, 0, 0,            1, 32'h0,     0, 0));
        tbl.push_back(mk(1, 0, 0, 0,           0, 0, 0,            1, 4,  0, 0, 0,            1, 32'h10,    0, 0));
        tbl.push_back(mk(1, 0, 0, 0,           0, 0, 0,            0, 0,  0, 0, 0,            1, 32'h10,    0, 1));

        // First reset edge holds s_valid high; the table's first row is the second reset cycle.
        drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 32'h1, 1'b0, 5'd0);
        foreach (tbl[i]) begin
            v = tbl[i];
            drive(v.rst_n, v.p_we, v.p_wa, v.p_wd, v.s_valid, v.s_wa, v.s_wd, v.iss_valid, v.iss_wa);
            chk($sformatf("row%0d we3", i), {31'b0, we3}, {31'b0, v.e_we});
            chk($sformatf("row%0d wa3", i), {27'b0, wa3}, {27'b0, v.e_wa});
            chk($sformatf("row%0d wd3", i), wd3, v.e_wd);
            chk($sformatf("row%0d s_ready", i), {31'b0, s_ready}, {31'b0, v.e_rdy});
            chk($sformatf("row%0d busy", i), busy, v.e_busy);
            chk($sformatf("row%0d stall_req", i), {31'b0, stall_req}, {31'b0, v.e_stall});
            chk($sformatf("row%0d waw_err", i), {31'b0, waw_err}, {31'b0, v.e_waw});
        end

        // Fill the FIFO behind a busy pipeline, then drain in order with s_valid held.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 5'd1, 32'hAA, 1'b1, 5'(10 + i), 32'h100 + 32'(i), 1'b0, 5'd0);
            chk($sformatf("fill%0d s_ready", i), {31'b0, s_ready}, 32'd1);
            chk($sformatf("fill%0d wa3", i), {27'b0, wa3}, 32'd1);
        end
        drive(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd20, 32'hEEE, 1'b0, 5'd0);
        chk("full s_ready", {31'b0, s_ready}, 32'd0);
        chk("full pop0 wa3", {27'b0, wa3}, 32'd10);
        chk("full pop0 wd3", wd3, 32'h100);
        drive(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd20, 32'hEEE, 1'b0, 5'd0);
        chk("after pop s_ready", {31'b0, s_ready}, 32'd1);
        chk("pop1 wa3", {27'b0, wa3}, 32'd11);
        for (int i = 2; i < 4; i++) begin
            idle();
            chk($sformatf("pop%0d we3", i), {31'b0, we3}, 32'd1);
            chk($sformatf("pop%0d wa3", i), {27'b0, wa3}, 32'(10 + i));
            chk($sformatf("pop%0d wd3", i), wd3, 32'h100 + 32'(i));
        end
        idle();
        chk("pop4 wa3", {27'b0, wa3}, 32'd20);
        chk("pop4 wd3", wd3, 32'hEEE);
        idle();
        chk("drained we3", {31'b0, we3}, 32'd0);

        // Starvation: head waits under a continuous pipeline write until stall_req.
        do_reset();
        drive(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd12, 32'h77, 1'b0, 5'd0);
        n = 0;
        while (n < 20) begin
            drive(1'b1, 1'b1, 5'd1, 32'h5, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
            if (stall_req) break;
            n++;
        end
        chk("starve cycles", 32'(n), 32'd8);
        drive(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        chk("starve stall held", {31'b0, stall_req}, 32'd1);
        chk("starve pop wa3", {27'b0, wa3}, 32'd12);
        chk("starve pop wd3", wd3, 32'h77);
        idle();
        chk("starve stall drop", {31'b0, stall_req}, 32'd0);
        chk("starve empty we3", {31'b0, we3}, 32'd0);

        // Reset mid-operation discards buffered entries.
        do_reset();
        drive(1'b1, 1'b1, 5'd1, 32'h1, 1'b1, 5'd6, 32'h66, 1'b0, 5'd0);
        drive(1'b1, 1'b1, 5'd1, 32'h1, 1'b1, 5'd8, 32'h88, 1'b0, 5'd0);
        drive(1'b0, 1'b1, 5'd1, 32'h1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        idle();
        chk("midreset we3", {31'b0, we3}, 32'd0);
        chk("midreset s_ready", {31'b0, s_ready}, 32'd1);
        idle();
        chk("midreset we3 later", {31'b0, we3}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
